contador_param: RTL
===================

Name: contador_param

Overview:
- Parametrised successor to the transaction-layer FIFO activity counter.
- Keeps one counter per channel and increments it on each per-channel push strobe.
- Provides single-channel reads (req/idx) and a sequential all-channel dump, with selectable saturate or wrap mode, optional clear-on-read, and sticky overflow flags.
- Sits between the FIFO bank and the transaction-layer FSM, which drives init/idle.

Parameters:
N_CH, 4, number of channels (2..16)
CNT_W, 5, counter and data_out width
IDX_W, 2, channel index width; must satisfy 2**IDX_W >= N_CH
SATURATE, 0, 1 = counters stick at all-ones; 0 = counters wrap to 0

Ports:
clk  in  1  clock, all state changes on rising edge
reset_L  in  1  asynchronous active-low reset
init  in  1  synchronous clear of counters, flags and FSM (FSM RESET state)
idle  in  1  reads/dumps are accepted only while high (FSM IDLE state)
push  in  N_CH  per-channel count strobe, bit k increments counter k
req  in  1  single-channel read request
idx  in  IDX_W  channel selected for a single read
dump_req  in  1  request to read all channels in order 0..N_CH-1
clr_on_rd  in  1  when high, each counter that is read is cleared
valid  out  1  data_out/idx_out qualified, one-cycle pulse per word
data_out  out  CNT_W  counter value read
idx_out  out  IDX_W  channel that data_out belongs to
last  out  1  high with valid on the final word of a dump
busy  out  1  dump in progress
err  out  1  one-cycle pulse: req with idx >= N_CH
ovf  out  N_CH  sticky per-channel overflow flag

Behaviour:
- reset_L low (async): all counters = 0, ovf = 0, valid = last = err = busy = 0, data_out = 0, idx_out = 0, FSM = S_IDLE.
- init high (sync) has the same effect as reset on the next edge and overrides every other input.
- Counting:
  - push[k] high at an edge: cnt[k] <= cnt[k]+1.
  - At all-ones with SATURATE=1: cnt[k] holds and ovf[k] <= 1.
  - At all-ones with SATURATE=0: cnt[k] <= 0 and ovf[k] <= 1.
  - ovf[k] clears only on reset/init, or when channel k is read with clr_on_rd=1.
  - Counting continues regardless of idle, busy or dump.
- FSM states: S_IDLE, S_DUMP.
- S_IDLE, priority order (highest first):
  - init.
  - idle & dump_req: go to S_DUMP, busy <= 1, pointer <= 0, clr_on_rd latched for the whole dump.
  - idle & req & idx < N_CH: single read.
  - idle & req & idx >= N_CH: err pulse, valid stays 0.
  - idle low: req/dump_req ignored, valid <= 0.
- Single read: at the sampling edge, data_out <= cnt[idx] (value before any same-edge push), idx_out <= idx, valid <= 1 for exactly one cycle. Latency = 1 cycle from req to valid. A held req produces a read every cycle.
- S_DUMP:
  - One word per cycle starting at the first edge after entry: data_out <= cnt[ptr], idx_out <= ptr, valid <= 1, ptr++.
  - At ptr == N_CH-1: last <= 1, return to S_IDLE, busy <= 0.
  - Total N_CH valid cycles. req and dump_req are ignored while busy; the dump is not aborted by idle falling.
  - init mid-dump: abort, outputs cleared next edge.
- Clear-on-read, same edge as the read:
  - cnt[ch] <= 0 and ovf[ch] <= 0.
  - If push[ch] is also high, cnt[ch] <= 1 (the push is never lost), and data_out carries the pre-increment value.
- data_out/idx_out hold their last value when valid = 0.

Test Plan:
1. Reset then 3 pushes on ch2, then req with idx=2 -> next cycle valid=1, data_out=3, idx_out=2; one cycle later valid=0.
2. SATURATE=0, CNT_W=5, 33 pushes on ch0, then read ch0 -> data_out=1, ovf[0]=1. SATURATE=1, same stimulus -> data_out=31, ovf[0]=1.
3. Counts {1,2,3,4} on ch0..3, then dump_req with clr_on_rd=1 -> 4 consecutive valids with data 1,2,3,4, idx 0..3, last on 4th, busy high 4 cycles. Follow with a dump -> all 0.
4. push[1] and a clr_on_rd read of ch1 in the same cycle with cnt[1]=7 -> data_out=7, later read -> 1.
5. req with idx=3 and N_CH=3 -> err pulse, no valid. req while idle=0 -> no valid. req during dump -> ignored.
6. Assert reset_L low mid-dump, asynchronously between edges -> valid, busy, last and data_out go 0 immediately; counters 0 after release.

Source files
------------

// File: rtl/contador_param_if.sv
// Bundles the counter block's control, read and status signals between the
// FIFO bank / transaction-layer FSM side (master) and the counter (slave).
interface contador_param_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 5,
  parameter int IDX_W = 2
);
  logic             init;
  logic             idle;
  logic [N_CH-1:0]  push;
  logic             req;
  logic [IDX_W-1:0] idx;
  logic             dump_req;
  logic             clr_on_rd;
  logic             valid;
  logic [CNT_W-1:0] data_out;
  logic [IDX_W-1:0] idx_out;
  logic             last;
  logic             busy;
  logic             err;
  logic [N_CH-1:0]  ovf;

  modport master (
    output init, idle, push, req, idx, dump_req, clr_on_rd,
    input  valid, data_out, idx_out, last, busy, err, ovf
  );

  modport slave (
    input  init, idle, push, req, idx, dump_req, clr_on_rd,
    output valid, data_out, idx_out, last, busy, err, ovf
  );
endinterface

// File: rtl/contador_param.sv
// Per-channel push counters with single-channel reads, sequential dump,
// wrap/saturate mode, clear-on-read and sticky overflow flags.
module contador_param #(
  parameter int N_CH     = 4,
  parameter int CNT_W    = 5,
  parameter int IDX_W    = 2,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset_L,
  contador_param_if.slave  bus
);

  localparam int IDX_SPAN = 1 << IDX_W;
  // Bit i set when index i names an existing channel.
  localparam logic [IDX_SPAN-1:0] IDX_OK   = IDX_SPAN'((64'd1 << N_CH) - 64'd1);
  localparam logic [IDX_W-1:0]    LAST_PTR = IDX_W'(N_CH - 1);

  typedef enum logic {S_IDLE, S_DUMP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt [N_CH];
  logic [N_CH-1:0]  ovf_q;
  logic [IDX_W-1:0] ptr;
  logic             clr_lat;

  logic             valid_q;
  logic             last_q;
  logic             err_q;
  logic [CNT_W-1:0] data_q;
  logic [IDX_W-1:0] idx_q;

  logic             idx_ok;
  logic             rd_en;
  logic             rd_clr;
  logic [IDX_W-1:0] rd_ch;
  logic [N_CH-1:0]  clr_hit;
  logic [CNT_W-1:0] rd_val;

  assign idx_ok = IDX_OK[bus.idx];
  assign rd_val = cnt[rd_ch];

  // Which channel (if any) is read this edge, and whether that read clears it.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    rd_en   = 1'b0;
    rd_clr  = 1'b0;
    rd_ch   = ptr;
    clr_hit = '0;
    if (state == S_DUMP) begin
      rd_en  = 1'b1;
      rd_clr = clr_lat;
    end else if (bus.idle && !bus.dump_req && bus.req && idx_ok) begin
      rd_en  = 1'b1;
      rd_ch  = bus.idx;
      rd_clr = bus.clr_on_rd;
    end
    for (int k = 0; k < N_CH; k++) begin
      clr_hit[k] = rd_en && rd_clr && (rd_ch == IDX_W'(k));
    end
  end

  // Counters run independently of the read FSM; a clearing read keeps a same-edge push.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      // NOTE: the counter array is plain flops that must start at zero, so it is reset like any other state.
      for (int k = 0; k < N_CH; k++) cnt[k] <= '0;
      ovf_q <= '0;
    end else if (bus.init) begin
      for (int k = 0; k < N_CH; k++) cnt[k] <= '0;
      ovf_q <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (clr_hit[k]) begin
          cnt[k]   <= bus.push[k] ? CNT_W'(1) : '0;
          ovf_q[k] <= 1'b0;
        end else if (bus.push[k]) begin
          if (&cnt[k]) begin
            ovf_q[k] <= 1'b1;
            if (SATURATE == 0) cnt[k] <= '0;
          end else begin
            cnt[k] <= cnt[k] + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state   <= S_IDLE;
      ptr     <= '0;
      clr_lat <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
    end else if (bus.init) begin
      state   <= S_IDLE;
      ptr     <= '0;
      clr_lat <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
    end else begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.idle) begin
            if (bus.dump_req) begin
              state   <= S_DUMP;
              ptr     <= '0;
              clr_lat <= bus.clr_on_rd;
            end else if (bus.req) begin
              if (idx_ok) begin
                valid_q <= 1'b1;
                data_q  <= rd_val;
                idx_q   <= bus.idx;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
        end
        S_DUMP: begin
          valid_q <= 1'b1;
          data_q  <= rd_val;
          idx_q   <= ptr;
          if (ptr == LAST_PTR) begin
            last_q <= 1'b1;
            state  <= S_IDLE;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.valid    = valid_q;
  assign bus.data_out = data_q;
  assign bus.idx_out  = idx_q;
  assign bus.last     = last_q;
  assign bus.busy     = (state == S_DUMP);
  assign bus.err      = err_q;
  assign bus.ovf      = ovf_q;

endmodule
